// File: rtl/panel_pkg.sv
// Shared types and default widths for the front-panel display arbiter.
// Pure declarations: no logic, no latency, no flow control.
package panel_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    SWITCH = 2'd2
  } arb_state_t;

  localparam int PANEL_SEG_W = 8;
  localparam int PANEL_LED_W = 120;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit scanning upward from last+1 with wrap.
// Zero latency; no backpressure, the caller decides when to act on the pick.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic             any_valid,
  output logic [IDX_W-1:0] winner
);

  logic [IDX_W-1:0] idx;

  // Scan from the farthest offset down so the nearest candidate after last overwrites.
  always_comb begin
    any_valid = 1'b0;
    winner    = '0;
    idx       = '0;
    for (int k = N; k >= 1; k--) begin
      idx = IDX_W'((int'(last) + k) % N);
      if (req[idx]) begin
        any_valid = 1'b1;
        winner    = idx;
      end
    end
  end

endmodule

// File: rtl/panel_display_arbiter.sv
// Round-robin owner of the panel display with a minimum dwell and a one-cycle blank between owners.
// Grant registered one edge after req; panel data lags grant by one edge; requesters just keep req high.
module panel_display_arbiter
  import panel_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DWELL_CYCLES = 1000,
  parameter int SEG_W        = PANEL_SEG_W,
  parameter int LED_W        = PANEL_LED_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*SEG_W-1:0]   seg_in,
  input  logic [NUM_REQ*LED_W-1:0]   ledr_in,
  input  logic [NUM_REQ*LED_W-1:0]   ledg_in,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] owner_id,
  output logic                       busy,
  output logic [SEG_W-1:0]           sevensegment_2,
  output logic [LED_W-1:0]           led_r,
  output logic [LED_W-1:0]           led_g
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(DWELL_CYCLES - 1);

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   dwell_q, dwell_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               busy_q, busy_d;
  logic [SEG_W-1:0]   seg_q, seg_d;
  logic [LED_W-1:0]   ledr_q, ledr_d;
  logic [LED_W-1:0]   ledg_q, ledg_d;

  logic               pick_vld;
  logic [IDX_W-1:0]   pick_idx;
  logic               owner_drop;
  logic               preempt;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req       (req),
    .last      (last_q),
    .any_valid (pick_vld),
    .winner    (pick_idx)
  );

  assign owner_drop = !req[owner_q];
  assign preempt    = (dwell_q == DWELL_MAX) && |(req & ~grant_q);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    dwell_d = dwell_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    seg_d   = '0;
    ledr_d  = '0;
    ledg_d  = '0;
    unique case (state_q)
      IDLE, SWITCH: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
        if (pick_vld) begin
          state_d = HOLD;
          grant_d = NUM_REQ'(1) << pick_idx;
          owner_d = pick_idx;
          last_d  = pick_idx;
          busy_d  = 1'b1;
          dwell_d = '0;
        end
      end
      HOLD: begin
        dwell_d = (dwell_q == DWELL_MAX) ? dwell_q : dwell_q + 1'b1;
        // Blank on the exit edge so the SWITCH cycle shows no grant and no data together.
        if (owner_drop || preempt) begin
          state_d = SWITCH;
          grant_d = '0;
          busy_d  = 1'b0;
        end else begin
          seg_d  = seg_in[owner_q*SEG_W +: SEG_W];
          ledr_d = ledr_in[owner_q*LED_W +: LED_W];
          ledg_d = ledg_in[owner_q*LED_W +: LED_W];
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= IDX_W'(NUM_REQ - 1);
      owner_q <= '0;
      dwell_q <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      seg_q   <= '0;
      ledr_q  <= '0;
      ledg_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      dwell_q <= dwell_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      seg_q   <= seg_d;
      ledr_q  <= ledr_d;
      ledg_q  <= ledg_d;
    end
  end

  assign grant          = grant_q;
  assign owner_id       = owner_q;
  assign busy           = busy_q;
  assign sevensegment_2 = seg_q;
  assign led_r          = ledr_q;
  assign led_g          = ledg_q;

endmodule

// File: doc/panel_display_arbiter.md
Name: panel_display_arbiter

Overview:
Shares the front-panel display resources (sevensegment_2, led_r, led_g) between up to NUM_REQ independent requesters, such as a status engine, a debug view and a game view. The block uses round-robin arbitration with a minimum dwell time. It inserts a one-cycle blank between owners. Its outputs drive the panel top-level display pins directly, all registered.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DWELL_CYCLES, 1000, minimum grant hold in clk cycles before preemption (>=2)
SEG_W, 8, seven-segment bus width
LED_W, 120, width of each LED bank

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
req  input  NUM_REQ  per-requester display request, level
seg_in  input  NUM_REQ*SEG_W  requester i segment data at [i*SEG_W +: SEG_W]
ledr_in  input  NUM_REQ*LED_W  requester i red bank at [i*LED_W +: LED_W]
ledg_in  input  NUM_REQ*LED_W  requester i green bank, same packing
grant  output  NUM_REQ  one-hot grant, registered
owner_id  output  $clog2(NUM_REQ)  index of current owner, valid when busy
busy  output  1  high while a grant is held
sevensegment_2  output  SEG_W  registered panel segment drive
led_r  output  LED_W  registered red bank drive
led_g  output  LED_W  registered green bank drive

Behaviour:
- Reset is async on rst_n low. grant=0, owner_id=0, busy=0, all display outputs=0, state=IDLE, dwell_cnt=0. The round-robin pointer last resets to NUM_REQ-1, so requester 0 wins first.
- States are IDLE, HOLD and SWITCH.
- IDLE:
  - Display outputs load 0.
  - If req!=0, the next edge moves to HOLD with grant=onehot(winner), owner_id=winner, busy=1, dwell_cnt=0.
- Winner selection: the first set req bit scanning from (last+1) mod NUM_REQ upward with wrap. Entering HOLD sets last=winner.
- HOLD:
  - Each edge loads sevensegment_2/led_r/led_g from the owner's slice. Panel data therefore lags grant by one cycle.
  - dwell_cnt increments and saturates at DWELL_CYCLES-1.
  - Owner req low moves to SWITCH on the next edge, regardless of dwell_cnt.
  - If dwell_cnt==DWELL_CYCLES-1 and any other req bit is set, move to SWITCH. A preempted owner therefore holds grant for exactly DWELL_CYCLES cycles.
  - If no other requester is pending, hold indefinitely.
  - If both exit conditions occur in the same cycle, the result is a single SWITCH.
- SWITCH (exactly one cycle):
  - grant=0, busy=0, display outputs load 0 (blank).
  - Next edge: if req!=0, go to HOLD with a new winner using the same rule. Otherwise go to IDLE.
  - A preempted owner still requesting has lowest priority in that pick.
- req changes during SWITCH are sampled at the SWITCH cycle only. No combinational path runs from req to grant.
- Slice data changes while held pass through with one-cycle latency and no filtering.
- Reset asserted mid-HOLD clears all outputs immediately, without waiting for a clock. The pointer returns to NUM_REQ-1.
- dwell_cnt width is $clog2(DWELL_CYCLES).

Decomposition:
- Package panel_pkg holds:
  - the arb_state_t enum {IDLE, HOLD, SWITCH}
  - the PANEL_SEG_W=8 and PANEL_LED_W=120 constants
- Sub-module rr_pick is purely combinational. Inputs are req and last; outputs are any_valid and winner index. It is reused by future button/joystick input arbiters.

Test Plan:
(All tests use NUM_REQ=4, DWELL_CYCLES=8.)
1. Reset: rst_n low mid-clock -> grant=0, busy=0, led_r=led_g=0, sevensegment_2=0 immediately. Release with req=0 -> stays IDLE, outputs 0.
2. Single owner: req=4'b0010, seg_in[1]=8'hA5 -> grant=4'b0010 after 1 edge, sevensegment_2=8'hA5 one edge later. Both remain unchanged for 50 cycles.
3. Simultaneous: req=4'b0101 from IDLE -> grant 0 for exactly 8 cycles, 1 blank cycle (grant=0, outputs 0), then grant=4'b0100, owner_id=2.
4. Early release: owner 0 drops req after 3 cycles of HOLD with req1 high -> grant=0 next edge, 1 blank cycle, then grant=4'b0010.
5. Full rotation: req=4'b1111 constant -> owner sequence 0,1,2,3,0. Each owner holds 8 cycles separated by 1 blank, giving a 36-cycle period.
6. Reset mid-HOLD with req=4'b1111 -> after release, requester 0 wins again (pointer reset) and the dwell count restarts at 0.
